// File: rtl/mc_control.sv
// rtl/mc_control.sv - multicycle MIPS main control FSM
//
// Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// datapath enables and mux selects of a shared-memory multicycle CPU.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   op                opcode IR[31:26], sampled in DECODE and MEMADR
//   mem_ready         memory access completes this cycle
//   aluctr            to ALU-control decoder (00 add, 01 sub, 10 R-type)
//   alusrca/alusrcb   ALU operand selects
//   pcsource          PC next-value select
//   pcwrite/pcwritecond/irwrite/regwrite/memwrite  write enables
//   iord/memread      memory address select, read strobe
//   regdst/memtoreg   register-file write address/data selects
//   state             current state (debug)
//   illegal_op        unsupported opcode seen in DECODE
//   instr_done        pulse on the last cycle of each instruction
//   instr_cnt         retired (legal) instruction count, wraps

module mc_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       op,
    input  logic             mem_ready,
    output logic [1:0]       aluctr,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsource,
    output logic             pcwrite,
    output logic             pcwritecond,
    output logic             iord,
    output logic             memread,
    output logic             memwrite,
    output logic             irwrite,
    output logic             regwrite,
    output logic             regdst,
    output logic             memtoreg,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;

    // Raw enables before reset gating
    logic w_pcwrite;
    logic w_pcwritecond;
    logic w_irwrite;
    logic w_memwrite;
    logic w_regwrite;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = S_FETCH;
        aluctr        = 2'b00;
        alusrca       = 1'b0;
        alusrcb       = 2'b00;
        pcsource      = 2'b00;
        iord          = 1'b0;
        memread       = 1'b0;
        regdst        = 1'b0;
        memtoreg      = 1'b0;
        illegal_op    = 1'b0;
        instr_done    = 1'b0;
        w_pcwrite     = 1'b0;
        w_pcwritecond = 1'b0;
        w_irwrite     = 1'b0;
        w_memwrite    = 1'b0;
        w_regwrite    = 1'b0;

        case (r_state)
            S_FETCH: begin
                memread   = 1'b1;
                alusrcb   = 2'b01;
                // PC+4 and IR load land together in the cycle memory delivers
                w_pcwrite = mem_ready;
                w_irwrite = mem_ready;
                w_next    = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut during decode
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_ADDIEX;
                    default: begin
                        illegal_op = 1'b1;
                        instr_done = 1'b1;
                        w_next     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                if (op == OP_LW) begin
                    w_next = S_MEMRD;
                end else if (op == OP_SW) begin
                    w_next = S_MEMWR;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                w_next  = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                w_regwrite = 1'b1;
                memtoreg   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                w_memwrite = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
                w_next     = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluctr  = 2'b10;
                w_next  = S_RWB;
            end
            S_RWB: begin
                w_regwrite = 1'b1;
                regdst     = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alusrca       = 1'b1;
                aluctr        = 2'b01;
                w_pcwritecond = 1'b1;
                pcsource      = 2'b01;
                instr_done    = 1'b1;
            end
            S_JUMP: begin
                w_pcwrite  = 1'b1;
                pcsource   = 2'b10;
                instr_done = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_next  = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_regwrite = 1'b1;
                instr_done = 1'b1;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Architectural writes are masked while reset is held so a reset landing
    // mid-instruction cannot leave a partial update behind
    assign pcwrite     = w_pcwrite     & rst_n;
    assign pcwritecond = w_pcwritecond & rst_n;
    assign irwrite     = w_irwrite     & rst_n;
    assign memwrite    = w_memwrite    & rst_n;
    assign regwrite    = w_regwrite    & rst_n;

    // Illegal opcodes end the instruction but are not counted as retired
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (instr_done && !illegal_op) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign state     = r_state;
    assign instr_cnt = r_cnt;

endmodule
